// File: rtl/spi_shift_reg.sv
// SPI data shifter: parallel load, serial shift, bit counter and control FSM.
// Emits a one-cycle done pulse when a full word has been shifted.
module spi_shift_reg #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q;
  logic             load_acc;
  logic             shift_acc;
  logic             last_shift;

  always_comb begin
    load_acc   = load & (state_q != SHIFT);
    shift_acc  = shift_en & (state_q == SHIFT);
    last_shift = shift_acc & (cnt_q == LAST);
  end

  // sin always enters the bit position vacated by the shift
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {q_q[WIDTH-2:0], sin};
      assign sout    = q_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {sin, q_q[WIDTH-1:1]};
      assign sout    = q_q[0];
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign q_d[i] = load_acc  ? din[i]     :
                      shift_acc ? shifted[i] :
                                  q_q[i];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (load_acc) begin
      cnt_d = '0;
    end else if (shift_acc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_acc) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = load_acc ? SHIFT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign dout    = q_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_spi_shift_reg.sv
// Randomised bench for spi_shift_reg: MSB-first and LSB-first instances
// checked every cycle against a word-level model, plus directed scenarios.
module tb_spi_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       shift_en;
  logic       sin;

  logic       sout_m, sout_l;
  logic [7:0] dout_m, dout_l;
  logic       busy_m, busy_l;
  logic       done_m, done_l;
  logic [3:0] cnt_m, cnt_l;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  // model: index 0 = MSB-first, 1 = LSB-first; phase 0 idle, 1 shift, 2 done
  logic [7:0] mq   [2];
  int         mcnt [2];
  int         mph  [2];

  always #5 clk = ~clk;

  spi_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .shift_en(shift_en), .sin(sin), .sout(sout_m),
    .dout(dout_m), .busy(busy_m), .done(done_m), .bit_cnt(cnt_m)
  );

  spi_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .shift_en(shift_en), .sin(sin), .sout(sout_l),
    .dout(dout_l), .busy(busy_l), .done(done_l), .bit_cnt(cnt_l)
  );

  task automatic check(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k] = 8'h00; mcnt[k] = 0; mph[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mph[k] == 1) begin
          if (shift_en) begin
            if (k == 0) mq[k] = 8'((int'(mq[k]) * 2 + int'(sin)) % 256);
            else        mq[k] = 8'(int'(mq[k]) / 2 + int'(sin) * 128);
            mcnt[k] = mcnt[k] + 1;
            if (mcnt[k] == 8) mph[k] = 2;
          end
        end else if (load) begin
          mq[k] = din; mcnt[k] = 0; mph[k] = 1;
        end else if (mph[k] == 2) begin
          mph[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      check("sout", 0, 32'(sout_m), 32'(mq[0][7]));
      check("sout", 1, 32'(sout_l), 32'(mq[1][0]));
      check("dout", 0, 32'(dout_m), 32'(mq[0]));
      check("dout", 1, 32'(dout_l), 32'(mq[1]));
      check("busy", 0, 32'(busy_m), 32'(mph[0] == 1));
      check("busy", 1, 32'(busy_l), 32'(mph[1] == 1));
      check("done", 0, 32'(done_m), 32'(mph[0] == 2));
      check("done", 1, 32'(done_l), 32'(mph[1] == 2));
      check("bit_cnt", 0, 32'(cnt_m), 32'(mcnt[0]));
      check("bit_cnt", 1, 32'(cnt_l), 32'(mcnt[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic [7:0] d,
                        input logic se, input logic si);
    load = ld; din = d; shift_en = se; sin = si;
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 0, 32'(busy_m), 32'd0);
    check("rst_sout", 0, 32'(sout_m), 32'd0);
    check("rst_dout", 0, 32'(dout_m), 32'd0);
    check("rst_done", 0, 32'(done_m), 32'd0);
    check("rst_cnt", 1, 32'(cnt_l), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] seq;
  int         ticks;
  bit         got;

  initial begin
    rst = 1'b1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("reset_busy", 0, 32'(busy_m), 32'd0);
    check("reset_done", 0, 32'(done_m), 32'd0);
    check("reset_sout", 0, 32'(sout_m), 32'd0);
    check("reset_dout", 1, 32'(dout_l), 32'd0);
    check("reset_cnt", 0, 32'(cnt_m), 32'd0);
    tick();
    rst = 1'b0;
    run = 1'b1;
    tick();

    // MSB-first transmit of A5 with sin=0
    set_in(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    seq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      seq = {seq[6:0], sout_m};
      tick();
    end
    check("t1_sout_seq", 0, 32'(seq), 32'hA5);
    check("t1_done", 0, 32'(done_m), 32'd1);
    check("t1_dout", 0, 32'(dout_m), 32'h00);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // loopback
    set_in(1'b1, 8'hA5, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 8'h00, 1'b1, sout_m);
      tick();
    end
    check("t2_dout", 0, 32'(dout_m), 32'hA5);
    check("t2_done", 0, 32'(done_m), 32'd1);
    check("t2_busy", 0, 32'(busy_m), 32'd0);
    check("t2_cnt", 0, 32'(cnt_m), 32'd8);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // LSB-first, din=01, sin=1
    set_in(1'b1, 8'h01, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b1);
    seq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      seq[i] = sout_l;
      tick();
    end
    check("t3_sout_seq", 1, 32'(seq), 32'h01);
    check("t3_dout", 1, 32'(dout_l), 32'hFF);
    check("t3_done", 1, 32'(done_l), 32'd1);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // sparse ticks, load ignored mid-word
    set_in(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    ticks = 0;
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      set_in(c == 4, (c == 4) ? 8'hFF : 8'h5A, (c % 3) == 2, 1'($urandom));
      if (shift_en && busy_m) ticks++;
      tick();
      if (done_m) begin
        got = 1'b1;
        break;
      end
    end
    check("t4_done_seen", 0, 32'(got), 32'd1);
    check("t4_ticks", 0, 32'(ticks), 32'd8);

    // back-to-back load during DONE
    set_in(1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    check("t5_busy", 0, 32'(busy_m), 32'd1);
    check("t5_done", 0, 32'(done_m), 32'd0);
    check("t5_sout", 0, 32'(sout_m), 32'd0);
    set_in(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    check("t5_done2", 0, 32'(done_m), 32'd1);
    check("t5_dout", 0, 32'(dout_m), 32'hFF);
    tick();
    set_in(1'b1, 8'hC3, 1'b1, 1'b0);
    tick();
    check("t5_noshift_cnt", 0, 32'(cnt_m), 32'd0);
    check("t5_noshift_dout", 0, 32'(dout_m), 32'hC3);
    check("t5_noshift_sout", 0, 32'(sout_m), 32'd1);

    // reset mid-word
    set_in(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("t6_cnt", 0, 32'(cnt_m), 32'd3);
    set_in(1'b0, 8'h00, 1'b0, 1'b0);
    async_reset_check();
    tick();
    check("t6_no_done", 0, 32'(done_m), 32'd0);
    set_in(1'b1, 8'h96, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    check("t6_done", 0, 32'(done_m), 32'd1);
    check("t6_dout", 0, 32'(dout_m), 32'hFF);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      set_in($urandom_range(0, 7) == 0, 8'($urandom),
             1'($urandom), 1'($urandom));
      if ($urandom_range(0, 249) == 0) async_reset_check();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
